// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encodings, default sizes and the length field width for the sequence detector
package seq_det_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;
    localparam int MAXLEN_DEF = 8;
    localparam int CNT_W_DEF  = 8;
    localparam int LEN_W      = 5;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register, fill counter and masked pattern comparator
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_en_i,
    input  logic              clr_i,
    input  logic              in_bit_i,
    input  logic [MAXLEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              overlap_i,
    output logic              hit_o
);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAXLEN);
    // only MAXLEN-1 old bits are ever needed: the compare looks at the word including the incoming bit
    logic [MAXLEN-2:0] hist_q;
    logic [MAXLEN-1:0] hist_d, mask;
    logic [LEN_W-1:0]  fill_q;
    logic              full;
    // incoming history word and the mask selecting its low len bits
    always_comb begin
        hist_d = {hist_q, in_bit_i};
        for (int i = 0; i < MAXLEN; i++) mask[i] = i < int'(len_i);
    end
    assign full  = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_i};
    assign hit_o = shift_en_i && full && (((hist_d ^ pattern_i) & mask) == '0);
    // shift on every accepted bit; a non-overlapping hit restarts the fill
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en_i) begin
            hist_q <= hist_d[MAXLEN-2:0];
            fill_q <= (hit_o && !overlap_i) ? '0 : (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller for programmable sequence detection; SEQ_DET_TIMEOUT_EN adds an idle timeout
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAXLEN      = MAXLEN_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_we_i,
    input  logic [MAXLEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              cfg_overlap_i,
    input  logic [CNT_W-1:0]  cfg_thresh_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              in_valid_i,
    input  logic              in_bit_i,
    output logic              busy_o,
    output logic              match_o,
    output logic [CNT_W-1:0]  match_cnt_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic              timeout_o
);
    if (MAXLEN < 2 || MAXLEN > 16 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("seq_det_ctrl: parameter out of range");
    end
    state_e            state_q;
    logic [MAXLEN-1:0] pattern_q;
    logic [LEN_W-1:0]  len_q;
    logic              overlap_q;
    logic [CNT_W-1:0]  thresh_q, cnt_q, cnt_d;
    logic              match_q, done_q, cfg_err_q;
    logic              run, shift_en, clr, hit, len_ok, expire;
    assign run      = state_q == RUN;
    assign shift_en = run && in_valid_i && !stop_i;
    assign clr      = start_i && !stop_i && !run;
    assign cnt_d    = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign len_ok   = cfg_len_i != '0 && cfg_len_i <= LEN_W'(MAXLEN);
    seq_match_core #(.MAXLEN(MAXLEN)) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .shift_en_i(shift_en),
        .clr_i     (clr),
        .in_bit_i  (in_bit_i),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .overlap_i (overlap_q),
        .hit_o     (hit)
    );
`ifdef SEQ_DET_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_q;
    logic          timeout_q;
    assign expire    = run && !stop_i && !in_valid_i && idle_q == IW'(TIMEOUT_CYC - 1);
    assign timeout_o = timeout_q;
    // count consecutive idle cycles in RUN; the flag stays until the next start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (clr) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else if (expire) begin
            idle_q    <= '0;
            timeout_q <= 1'b1;
        end else begin
            idle_q <= (run && !in_valid_i) ? idle_q + 1'b1 : '0;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif
    // run FSM with configuration, match counter, threshold and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b1;
            thresh_q  <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            match_q <= 1'b0;
            if (cfg_we_i && !run) begin
                if (len_ok) begin
                    pattern_q <= cfg_pattern_i;
                    len_q     <= cfg_len_i;
                    overlap_q <= cfg_overlap_i;
                    thresh_q  <= cfg_thresh_i;
                end
                cfg_err_q <= !len_ok;
            end
            if (stop_i) begin
                state_q <= IDLE;
                done_q  <= 1'b0;
            end else if (clr) begin
                state_q <= RUN;
                cnt_q   <= '0;
                done_q  <= 1'b0;
            end else if (expire) begin
                state_q <= IDLE;
            end else if (hit) begin
                match_q <= 1'b1;
                cnt_q   <= cnt_d;
                if (thresh_q != '0 && cnt_d == thresh_q) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end
    assign busy_o      = run;
    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for programmable serial sequence detection. It holds a pattern of up to MAXLEN bits, arms and disarms detection, feeds the qualified input bits into a shift/compare core, and counts matches in overlapping or non-overlapping mode. After a programmed number of matches it stops and raises done. It sits between the serial bit source and the status/interrupt logic, in place of fixed-pattern detector FSMs.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and threshold
TIMEOUT_CYC, 64, idle-timeout cycle limit (used only with SEQ_DET_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
cfg_we  in  1  configuration write strobe
cfg_pattern  in  MAXLEN  pattern; pattern[len-1] is the first bit received
cfg_len  in  5  pattern length, legal 1..MAXLEN
cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping
cfg_thresh  in  CNT_W  match count that ends the run; 0 = run until stop
start  in  1  one-cycle pulse: begin a run
stop  in  1  one-cycle pulse: abort the run
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  serial data
busy  out  1  high in RUN
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches in the current or last run
done  out  1  threshold reached; level
cfg_err  out  1  sticky: illegal cfg_len written
timeout  out  1  sticky idle-timeout flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While rst is low, all state clears immediately: state=IDLE, busy=0, match=0, match_cnt=0, done=0, cfg_err=0, timeout=0. Configuration registers reset to pattern=0, len=1, overlap=1, thresh=0.
- States: IDLE, RUN, DONE. Encodings are 2'b00, 2'b01, 2'b10.
- Configuration:
  - cfg_we is honoured only in IDLE or DONE. It is ignored in RUN.
  - If cfg_len is 0 or greater than MAXLEN, the write is rejected entirely and cfg_err is set. cfg_err clears on the next legal write.
- Start:
  - start in IDLE or DONE moves the block to RUN.
  - It clears the history register, fill count, match_cnt, done and timeout.
  - start in RUN is ignored.
- Stop:
  - stop in RUN moves the block to IDLE.
  - match_cnt holds its value and done stays 0.
  - If start and stop arrive in the same cycle, stop wins and start is dropped.
- Shift and compare:
  - In RUN, each in_valid cycle shifts: hist <= {hist[MAXLEN-2:0], in_bit}. fill increments and saturates at MAXLEN.
  - in_valid outside RUN is ignored.
  - A match occurs when (fill+1) >= len and the low len bits of the new hist equal pattern[len-1:0].
- Match latency: match is a registered output. It pulses in the cycle after the edge that accepted the completing bit, one cycle after in_valid.
- On a match:
  - match_cnt increments and saturates at all-ones.
  - Non-overlapping mode: fill resets to 0, so the next match needs len fresh bits.
  - Overlapping mode: fill is kept.
- Threshold: if thresh != 0 and the incremented count equals thresh, the state moves to DONE on the same edge and done=1. Later bits are ignored.
- DONE exits only on start, stop or reset. stop in DONE moves to IDLE and clears done.
- Reset mid-run abandons the run with no match pulse.

Optional Feature:
SEQ_DET_TIMEOUT_EN
- Defined: a counter in RUN counts cycles with in_valid=0 and clears on every in_valid. When it reaches TIMEOUT_CYC, the block goes to IDLE and sets timeout (sticky until start or reset). match_cnt is preserved.
- Not defined: no counter exists and timeout is tied to 0.

Decomposition:
- Package seq_det_pkg holds:
  - state encodings IDLE, RUN, DONE
  - MAXLEN_DEF = 8 and CNT_W_DEF = 8
  - the length field width
- Sub-module seq_match_core holds the history shift register, fill counter, length mask and comparator. Its inputs are shift_en, clr, in_bit, pattern, len and overlap. Its output is hit (combinational).
- The controller FSM, counter, threshold logic and timeout live in seq_det_ctrl.

Test Plan:
- pattern=5'b10101, len=5, overlap=1, thresh=0; start; stream 1,0,1,0,1,0,1 → match pulses after the 5th and 7th bits; match_cnt=2.
- Same stream with overlap=0 → one match after the 5th bit; match_cnt=1.
- pattern=2'b11, len=2, thresh=3, overlap=1; stream 1,1,1,1,1 → matches after bits 2, 3 and 4; DONE with done=1 and busy=0; bit 5 is ignored; match_cnt=3.
- cfg_we with len=0 in IDLE → cfg_err=1, config unchanged. cfg_we in RUN → ignored. start and stop in the same cycle in IDLE → stays IDLE.
- Stream with in_valid gaps (bits 1,0,1 separated by idle cycles, len=3, pattern=3'b101) → exactly one match; rst asserted mid-stream → all outputs 0 immediately and no match pulse.
- With SEQ_DET_TIMEOUT_EN, TIMEOUT_CYC=4: start, then 4 idle cycles → IDLE with timeout=1.
